// File: rtl/bank_pkg.sv
// Shared widths, defaults and FSM encoding for the bank drain reader.
package bank_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_BANKS = 4;

    // Index width for a bank count; NUM_BANKS >= 2 keeps this at least 1.
    function automatic int idx_width(input int num_banks);
        return $clog2(num_banks);
    endfunction

    // Sum needs log2(NUM_BANKS) extra bits to hold NUM_BANKS * (2^DATA_W - 1).
    function automatic int sum_width(input int data_w, input int num_banks);
        return data_w + $clog2(num_banks);
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_NUM_BANKS);
    localparam int DEF_SUM_W = sum_width(DEF_DATA_W, DEF_NUM_BANKS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/bank_prio_enc.sv
// Purpose: lowest-set-bit priority encoder over a bank mask.
// Latency: purely combinational.
// Backpressure: none; output follows the mask directly.
module bank_prio_enc
    import bank_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    localparam int IDX_W = idx_width(NUM_BANKS)
)(
    input  logic [NUM_BANKS-1:0] mask,
    output logic [IDX_W-1:0]     index,
    output logic                 any
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/bank_drain_reader.sv
// Purpose: snapshots selected banks on start and streams them out in ascending index order, summing accepted beats.
// Latency: first beat valid 2 cycles after start; back-to-back beats with no bubbles; done 1 cycle after the last transfer.
// Backpressure: out_valid/out_ready; beat held stable while out_ready is low.
module bank_drain_reader
    import bank_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    localparam int IDX_W = idx_width(NUM_BANKS),
    localparam int SUM_W = sum_width(DATA_W, NUM_BANKS)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_BANKS-1:0]        bank_mask,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        busy,
    output logic                        done,
    output logic [SUM_W-1:0]            sum
);

    state_t                      state, state_nxt;
    logic [NUM_BANKS-1:0]        snap_mask;
    logic [NUM_BANKS*DATA_W-1:0] snap_data;
    logic [IDX_W-1:0]            cur_idx;
    logic [DATA_W-1:0]           cur_data;
    logic [NUM_BANKS-1:0]        mask_clr;
    logic [NUM_BANKS-1:0]        enc_in;
    logic [IDX_W-1:0]            enc_idx;
    logic                        enc_any;
    logic                        xfer;

    assign cur_data = snap_data[cur_idx*DATA_W +: DATA_W];
    assign mask_clr = snap_mask & ~(NUM_BANKS'(1) << cur_idx);

    // LOAD looks up the first bank; STREAM looks ahead to the bank after the one being accepted.
    assign enc_in = (state == ST_LOAD) ? snap_mask : mask_clr;

    bank_prio_enc #(
        .NUM_BANKS (NUM_BANKS)
    ) u_prio_enc (
        .mask  (enc_in),
        .index (enc_idx),
        .any   (enc_any)
    );

    assign out_valid = (state == ST_STREAM);
    assign xfer      = out_valid && out_ready;
    assign out_data  = out_valid ? cur_data : '0;
    assign out_idx   = out_valid ? cur_idx  : '0;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (|bank_mask) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD:   state_nxt = ST_STREAM;
            ST_STREAM: begin
                if (xfer && !enc_any) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_mask <= '0;
            snap_data <= '0;
            cur_idx   <= '0;
            sum       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sum <= '0;
                        if (|bank_mask) begin
                            snap_mask <= bank_mask;
                            snap_data <= bank_data;
                        end
                    end
                end
                ST_LOAD: begin
                    cur_idx <= enc_idx;
                end
                ST_STREAM: begin
                    if (xfer) begin
                        sum       <= sum + SUM_W'(cur_data);
                        snap_mask <= mask_clr;
                        cur_idx   <= enc_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_drain_reader.sv
// Scoreboard bench for bank_drain_reader: a reference model queues expected beats/sums, a negedge monitor checks them.
module tb_bank_drain_reader;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  bank_mask;
    logic [31:0] bank_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        busy;
    logic        done;
    logic [9:0]  sum;

    int checks;
    int errors;
    int done_cnt;
    int beats_seen;
    int ready_mode;
    bit stall_prev;
    logic [7:0] held_data;
    logic [1:0] held_idx;

    beat_t      exp_beats[$];
    logic [9:0] exp_sums[$];

    bank_drain_reader #(
        .DATA_W    (8),
        .NUM_BANKS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bank_mask (bank_mask),
        .bank_data (bank_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: beats are the set mask bits in ascending order, sum is their total.
    function automatic logic [9:0] model_push(input logic [3:0] m, input logic [31:0] d);
        logic [9:0] s;
        beat_t b;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                b.idx  = 2'(i);
                b.data = d[i*8 +: 8];
                exp_beats.push_back(b);
                s = s + 10'(d[i*8 +: 8]);
            end
        end
        exp_sums.push_back(s);
        return s;
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (stall_prev) begin
                    check("stall_data_stable", 32'(out_data), 32'(held_data));
                    check("stall_idx_stable", 32'(out_idx), 32'(held_idx));
                end
                if (out_ready) begin
                    beats_seen++;
                    stall_prev = 1'b0;
                    if (exp_beats.size() == 0) begin
                        check("unexpected_beat", 32'(out_idx), 32'hFFFF_FFFF);
                    end else begin
                        beat_t b;
                        b = exp_beats.pop_front();
                        check("beat_idx", 32'(out_idx), 32'(b.idx));
                        check("beat_data", 32'(out_data), 32'(b.data));
                    end
                end else begin
                    stall_prev = 1'b1;
                    held_data  = out_data;
                    held_idx   = out_idx;
                end
            end else begin
                if (stall_prev) check("valid_held_in_stall", 32'(out_valid), 32'd1);
                stall_prev = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("busy_in_done", 32'(busy), 32'd1);
                if (exp_sums.size() == 0) begin
                    check("unexpected_done", 32'(sum), 32'hFFFF_FFFF);
                end else begin
                    check("done_sum", 32'(sum), 32'(exp_sums.pop_front()));
                    check("beats_left_at_done", 32'(exp_beats.size()), 32'd0);
                end
            end
        end
    end

    task automatic run_drain(input logic [3:0] m, input logic [31:0] d, input int rmode, input bit disturb);
        int d0;
        int n;
        logic [9:0] s;
        ready_mode = rmode;
        @(posedge clk);
        #1;
        start     = 1'b1;
        bank_mask = m;
        bank_data = d;
        s  = model_push(m, d);
        d0 = done_cnt;
        n  = $countones(m);
        @(posedge clk);
        #1;
        start     = 1'b0;
        bank_data = $urandom;
        bank_mask = 4'($urandom);
        @(negedge clk);
        check("valid_low_after_start", 32'(out_valid), 32'd0);
        if (m == 4'b0000) begin
            check("empty_done_latency", 32'(done), 32'd1);
        end else begin
            check("busy_in_load", 32'(busy), 32'd1);
            @(negedge clk);
            check("first_valid_latency", 32'(out_valid), 32'd1);
            if (rmode == 0) begin
                for (int k = 1; k < n; k++) begin
                    @(negedge clk);
                    check("no_bubble", 32'(out_valid), 32'd1);
                end
                @(negedge clk);
                check("valid_falls_after_last", 32'(out_valid), 32'd0);
            end
        end
        if (disturb) begin
            @(posedge clk);
            #1;
            start     = 1'b1;
            bank_mask = 4'b1111;
            bank_data = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
            start     = 1'b0;
        end
        for (int c = 0; c < 200 && done_cnt == d0; c++) @(posedge clk);
        repeat (4) @(negedge clk);
        check("done_pulse_count", 32'(done_cnt - d0), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);
        check("sum_held", 32'(sum), 32'(s));
    endtask

    task automatic reset_mid_drain();
        int d0;
        int b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        bank_mask = 4'b1111;
        bank_data = 32'h4433_2211;
        void'(model_push(4'b1111, 32'h4433_2211));
        d0 = done_cnt;
        b0 = beats_seen;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 50 && beats_seen - b0 < 2; c++) @(posedge clk);
        check("beats_before_reset", 32'(beats_seen - b0), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        exp_beats.delete();
        exp_sums.delete();
        stall_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
        run_drain(4'b0110, 32'h0055_AA00, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        done_cnt   = 0;
        beats_seen = 0;
        ready_mode = 0;
        stall_prev = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        bank_mask  = '0;
        bank_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_idx", 32'(out_idx), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_drain(4'b1111, 32'h0403_0201, 0, 1'b0);
        run_drain(4'b1010, 32'hFFFF_FFFF, 1, 1'b0);
        run_drain(4'b0000, 32'h1234_5678, 0, 1'b0);
        run_drain(4'b1111, 32'hFFFF_FFFF, 0, 1'b0);
        run_drain(4'b1111, 32'h8070_6050, 1, 1'b1);
        reset_mid_drain();
        for (int t = 0; t < 20; t++) begin
            run_drain(4'($urandom), $urandom, int'($urandom_range(0, 2)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_beats_empty", 32'(exp_beats.size()), 32'd0);
        check("scoreboard_sums_empty", 32'(exp_sums.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_drain_reader.md
BANK_DRAIN_READER -- requirements
Module: bank_drain_reader

Interface
REQ-001 Parameter DATA_W, default 8, bank entry width in bits.
REQ-002 Parameter NUM_BANKS, default 4, number of banks; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a drain; sampled in IDLE only.
REQ-006 bank_mask  input  NUM_BANKS  banks to drain; bit i selects bank i.
REQ-007 bank_data  input  NUM_BANKS*DATA_W  packed bank contents; bank i at bits [i*DATA_W +: DATA_W].
REQ-008 out_valid  output  1  out_data/out_idx hold a valid beat.
REQ-009 out_ready  input  1  downstream accepts the beat.
REQ-010 out_data  output  DATA_W  current bank value.
REQ-011 out_idx  output  log2(NUM_BANKS)  bank index of the current beat.
REQ-012 busy  output  1  high in LOAD, STREAM and DONE.
REQ-013 done  output  1  one-cycle pulse at the end of a drain.
REQ-014 sum  output  DATA_W+log2(NUM_BANKS)  running total of accepted beats; final value valid when done=1.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, STREAM and DONE.
REQ-016 IDLE, start=1, bank_mask!=0: capture bank_data and bank_mask into snapshot registers, clear sum, go to LOAD.
REQ-017 IDLE, start=1, bank_mask==0: clear sum, go directly to DONE.
REQ-018 LOAD: compute the first index (lowest set bit of the snapshot mask), go to STREAM; first out_valid appears 2 cycles after start.
REQ-019 STREAM: out_valid=1; out_idx = lowest set bit of the remaining mask; out_data = snapshot[out_idx].
REQ-020 Handshake: a beat transfers on the cycle where out_valid and out_ready are both 1; out_data and out_idx SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 On transfer: sum += out_data (zero-extended); clear the mask bit; advance to the next set bit with no bubble cycle.
REQ-022 On transfer of the last set bit: out_valid falls next cycle and the FSM goes to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; sum holds its value until the next accepted start.
REQ-024 start is ignored while busy=1; bank_data and bank_mask changes after capture SHALL NOT affect the drain in progress.
REQ-025 Banks are drained in ascending index order; unselected banks are skipped with zero cycles spent.
REQ-026 sum SHALL NOT overflow: its width covers NUM_BANKS*(2^DATA_W-1).
REQ-027 out_valid SHALL be 0 in IDLE, LOAD and DONE.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, out_valid=0, done=0, busy=0, sum=0, out_data=0, out_idx=0, and clear the mask/data snapshot.
REQ-029 Reset asserted mid-drain SHALL abort the drain with no done pulse; after release the block is in IDLE and accepts start.

Structure
REQ-030 DATA_W and NUM_BANKS defaults, the derived index/sum widths, and the FSM state enum SHALL live in a shared package bank_pkg.
REQ-031 The lowest-set-bit priority encoder SHALL be a separate sub-module named bank_prio_enc (input mask, outputs index and any-set flag).

Verification
REQ-032 mask=4'b1111, data {8'h04,8'h03,8'h02,8'h01} (bank3..0), out_ready=1: beats idx 0,1,2,3 with data 01,02,03,04 on consecutive cycles; done with sum=10'h00A.
REQ-033 mask=4'b1010, data all 8'hFF, out_ready toggling 0/1: beats idx1 then idx3 only; data stays stable during stalls; sum=10'h1FE.
REQ-034 mask=4'b0000 with start: no out_valid; done pulses the cycle after start; sum=0.
REQ-035 mask=4'b1111, all 8'hFF, out_ready=1: sum=10'h3FC (no overflow); done pulses exactly once.
REQ-036 start re-pulsed and bank_data changed during STREAM: the original snapshot drains unaffected, and no second drain starts.
REQ-037 rst_n asserted after the 2nd beat: outputs go to reset values immediately with no done pulse; a new start after release drains correctly.
